memory_access_arbiter: RTL and testbench
========================================

// Module: memory_access_arbiter
// PURPOSE
//  Upstream front-end of the single-port MEMORY block. Arbitrates one writer and two readers (A, B) onto the shared
//  command bus (WriteEnable/Address/Readtoa/Readtob/DataIn), guarantees one-hot commands, and returns read data per port.
//  Memory read latency: 1 clock (data registered in MEMORY); this block aligns capture to that latency.
// PARAMETERS
//  DATA_WIDTH  8   data word width
//  ADDR_WIDTH  10  address width
//  MEM_SIZE    10  highest valid address (memory holds MEM_SIZE+1 words)
// PORTS
//  Clock            in   1           system clock, rising edge
//  Reset            in   1           asynchronous, active-high; clears all state and outputs
//  iWrReq           in   1           write request; held with iWrAddr/iWrData until oWrAck
//  iWrAddr          in   ADDR_WIDTH  write address
//  iWrData          in   DATA_WIDTH  write data
//  oWrAck           out  1           1-cycle pulse: write accepted
//  iRdReqA/iRdReqB  in   1           read request per port; held with address until ack
//  iRdAddrA/iRdAddrB in  ADDR_WIDTH  read address per port
//  oRdAckA/oRdAckB  out  1           1-cycle pulse: read accepted
//  oRdValidA/B      out  1           1-cycle pulse: oRdDataA/B valid
//  oRdDataA/B       out  DATA_WIDTH  read data; holds last value until next valid on that port
//  oAddrErr         out  1           1-cycle pulse with ack when address > MEM_SIZE
//  oMemWriteEnable  out  1           to MEMORY iWriteEnable
//  oMemReadtoa/b    out  1           to MEMORY iReadtoa / iReadtob
//  oMemAddress      out  ADDR_WIDTH  to MEMORY iAddress
//  oMemDataIn       out  DATA_WIDTH  to MEMORY iDataIn
//  iMemDataOuta/b   in   DATA_WIDTH  from MEMORY oDataOuta / oDataOutb
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, FSM=IDLE, RR pointer=last-granted B (writer first).
//  - FSM: IDLE -> ISSUE when any request (grant registered); ISSUE -> CAPTURE if read granted, else IDLE;
//    CAPTURE -> IDLE. IDLE with no request stays IDLE.
//  - Arbitration in IDLE only, 3-way round-robin W->A->B->W starting after last grant. Pointer updates on grant only.
//  - ISSUE cycle: ack of granted requester =1; exactly one of oMemWriteEnable/oMemReadtoa/oMemReadtob =1 with
//    oMemAddress (and oMemDataIn for write). Command lines =0 in every other state. Never two command bits at once.
//  - CAPTURE cycle: sample iMemDataOuta (port A) or iMemDataOutb (port B); next cycle oRdValidX=1, oRdDataX=sample.
//  - Read latency req->valid = 4 cycles (IDLE, ISSUE, CAPTURE, valid); write req->ack = 2 cycles. Min spacing
//    between grants: 2 cycles (write), 3 cycles (read). Requester drops req the cycle after ack; not re-granted in IDLE.
//  - Address > MEM_SIZE: still granted/acked in ISSUE with oAddrErr=1, no memory command bit asserted;
//    write discarded; read returns oRdDataX=0 with normal oRdValidX timing.
//  - Request dropped before ack: ignored if not yet granted; once granted, the command completes.
//  - Reset mid-operation: immediate clear; in-flight read produces no valid; pointer back to reset value.
//  - oMemDataIn driven to 0 on non-write cycles; data buses never tri-stated.
// STRUCTURE
//  - mem_arb_pkg: FSM state encoding (IDLE/ISSUE/CAPTURE), grant encoding (GNT_NONE/W/A/B), latency constants.
//  - Sub-module rr_arbiter_3: 3 requests + enable -> one-hot grant, owns RR pointer. Top holds FSM, cmd/capture regs.
// TESTING
//  - Reset: assert Reset mid-CAPTURE -> all outputs 0 same cycle; no oRdValidA after release.
//  - Write 0x5A @3, then RdA @3 -> oWrAck 2 cyc after req; oRdValidA 4 cyc after RdA req, oRdDataA=0x5A.
//  - All three req together (W@1=0x11, A@1, B@2) -> grants W,A,B in order; A reads 0x11; one cmd bit per cycle.
//  - Write @MEM_SIZE=10 then read @10 -> data returned; read @11 -> oAddrErr with ack, no cmd bit, oRdDataA=0.
//  - RdA and RdB held continuously -> strict alternation A,B,A,B; no starvation over 20 grants.
//  - Idle 10 cycles, no reqs -> all command outputs 0, no acks/valids.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory access arbiter: FSM state and grant
// encodings, default geometry of the MEMORY block, and the fixed request
// latencies seen by a requester.
package mem_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int MEM_SIZE_DEF   = 10;  // highest valid address

  // Cycles from the cycle a request is first presented (counted as 1)
  // to the cycle its response is visible.
  localparam int WR_ACK_LATENCY = 2;
  localparam int RD_LATENCY     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_W    = 2'd1,
    GNT_A    = 2'd2,
    GNT_B    = 2'd3
  } gnt_e;

endpackage

// File: rtl/rr_arbiter_3.sv
// Three-way round-robin arbiter. Bit 0 = writer, bit 1 = reader A,
// bit 2 = reader B. Priority rotates to start just after the last granted
// requester; the pointer only moves when a grant is actually issued.
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   en_i      arbitration allowed this cycle
//   req_i     request vector {B, A, W}
//   gnt_o     combinational one-hot grant (all zero when !en_i)
module rr_arbiter_3
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o
);

  // One-hot last-granted requester; resets to B so the writer wins first.
  logic [2:0] last_q, last_d;
  logic [2:0] gnt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    gnt = 3'b000;
    unique case (last_q)
      3'b001: begin  // last W -> A, B, W
        if      (req_i[1]) gnt = 3'b010;
        else if (req_i[2]) gnt = 3'b100;
        else if (req_i[0]) gnt = 3'b001;
      end
      3'b010: begin  // last A -> B, W, A
        if      (req_i[2]) gnt = 3'b100;
        else if (req_i[0]) gnt = 3'b001;
        else if (req_i[1]) gnt = 3'b010;
      end
      default: begin  // last B -> W, A, B
        if      (req_i[0]) gnt = 3'b001;
        else if (req_i[1]) gnt = 3'b010;
        else if (req_i[2]) gnt = 3'b100;
      end
    endcase
    if (!en_i) gnt = 3'b000;
    last_d = (gnt != 3'b000) ? gnt : last_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 3'b100;
    else     last_q <= last_d;
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/memory_access_arbiter.sv
// Front-end of the single-port MEMORY block. Arbitrates one writer and two
// readers onto the shared command bus, keeps commands one-hot, and returns
// read data per port, aligned to the 1-cycle registered read of MEMORY.
// Ports:
//   Clock, Reset                  clock / asynchronous active-high reset
//   iWrReq/iWrAddr/iWrData/oWrAck write request channel
//   iRdReqX/iRdAddrX/oRdAckX      read request channel, X = A, B
//   oRdValidX/oRdDataX            read response (data holds until next valid)
//   oAddrErr                      pulse with ack when address > MEM_SIZE
//   oMem*                         command bus towards MEMORY
//   iMemDataOuta/b                read data from MEMORY
// All outputs are registered.
module memory_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MEM_SIZE   = MEM_SIZE_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iWrReq,
  input  logic [ADDR_WIDTH-1:0] iWrAddr,
  input  logic [DATA_WIDTH-1:0] iWrData,
  output logic                  oWrAck,
  input  logic                  iRdReqA,
  input  logic                  iRdReqB,
  input  logic [ADDR_WIDTH-1:0] iRdAddrA,
  input  logic [ADDR_WIDTH-1:0] iRdAddrB,
  output logic                  oRdAckA,
  output logic                  oRdAckB,
  output logic                  oRdValidA,
  output logic                  oRdValidB,
  output logic [DATA_WIDTH-1:0] oRdDataA,
  output logic [DATA_WIDTH-1:0] oRdDataB,
  output logic                  oAddrErr,
  output logic                  oMemWriteEnable,
  output logic                  oMemReadtoa,
  output logic                  oMemReadtob,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  output logic [DATA_WIDTH-1:0] oMemDataIn,
  input  logic [DATA_WIDTH-1:0] iMemDataOuta,
  input  logic [DATA_WIDTH-1:0] iMemDataOutb
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_SIZE);

  state_e state_q, state_d;
  gnt_e   gnt_q, gnt_d;
  logic   err_q, err_d;  // granted address was out of range

  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_a_q, rd_ack_a_d, rd_ack_b_q, rd_ack_b_d;
  logic                  rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
  logic                  addr_err_q, addr_err_d;
  logic                  mem_we_q, mem_we_d, mem_ra_q, mem_ra_d, mem_rb_q, mem_rb_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;

  logic [2:0]            arb_gnt;
  logic [ADDR_WIDTH-1:0] req_addr;

  rr_arbiter_3 u_arb (
    .clk   (Clock),
    .rst   (Reset),
    .en_i  (state_q == ST_IDLE),
    .req_i ({iRdReqB, iRdReqA, iWrReq}),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    err_d        = err_q;
    wr_ack_d     = 1'b0;
    rd_ack_a_d   = 1'b0;
    rd_ack_b_d   = 1'b0;
    rd_valid_a_d = 1'b0;
    rd_valid_b_d = 1'b0;
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;
    addr_err_d   = 1'b0;
    mem_we_d     = 1'b0;
    mem_ra_d     = 1'b0;
    mem_rb_d     = 1'b0;
    mem_addr_d   = '0;
    mem_din_d    = '0;
    req_addr     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 3'b000) begin
          state_d = ST_ISSUE;
          if (arb_gnt[0]) begin
            gnt_d    = GNT_W;
            req_addr = iWrAddr;
          end else if (arb_gnt[1]) begin
            gnt_d    = GNT_A;
            req_addr = iRdAddrA;
          end else begin
            gnt_d    = GNT_B;
            req_addr = iRdAddrB;
          end
          err_d      = (req_addr > MAX_ADDR);
          addr_err_d = err_d;
          wr_ack_d   = arb_gnt[0];
          rd_ack_a_d = arb_gnt[1];
          rd_ack_b_d = arb_gnt[2];
          // Out-of-range requests are acked but never reach MEMORY.
          if (!err_d) begin
            mem_we_d   = arb_gnt[0];
            mem_ra_d   = arb_gnt[1];
            mem_rb_d   = arb_gnt[2];
            mem_addr_d = req_addr;
            if (arb_gnt[0]) mem_din_d = iWrData;
          end
        end
      end
      ST_ISSUE: begin
        // MEMORY registers the read during this cycle's closing edge.
        state_d = (gnt_q == GNT_W) ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
        if (gnt_q == GNT_A) begin
          rd_valid_a_d = 1'b1;
          rd_data_a_d  = err_q ? '0 : iMemDataOuta;
        end
        if (gnt_q == GNT_B) begin
          rd_valid_b_d = 1'b1;
          rd_data_b_d  = err_q ? '0 : iMemDataOutb;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_NONE;
      err_q        <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_a_q   <= 1'b0;
      rd_ack_b_q   <= 1'b0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      addr_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_ra_q     <= 1'b0;
      mem_rb_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      err_q        <= err_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_a_q   <= rd_ack_a_d;
      rd_ack_b_q   <= rd_ack_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      addr_err_q   <= addr_err_d;
      mem_we_q     <= mem_we_d;
      mem_ra_q     <= mem_ra_d;
      mem_rb_q     <= mem_rb_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign oWrAck          = wr_ack_q;
  assign oRdAckA         = rd_ack_a_q;
  assign oRdAckB         = rd_ack_b_q;
  assign oRdValidA       = rd_valid_a_q;
  assign oRdValidB       = rd_valid_b_q;
  assign oRdDataA        = rd_data_a_q;
  assign oRdDataB        = rd_data_b_q;
  assign oAddrErr        = addr_err_q;
  assign oMemWriteEnable = mem_we_q;
  assign oMemReadtoa     = mem_ra_q;
  assign oMemReadtob     = mem_rb_q;
  assign oMemAddress     = mem_addr_q;
  assign oMemDataIn      = mem_din_q;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed testbench for memory_access_arbiter with a behavioural 11-word
// MEMORY (1-cycle registered read). Inputs change and outputs are sampled
// on the falling clock edge. Cycle numbering: the cycle a request is first
// presented is cycle 1.
module tb_memory_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req, rd_req_a, rd_req_b;
  logic [9:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data;
  logic       wr_ack, rd_ack_a, rd_ack_b, rd_valid_a, rd_valid_b, addr_err;
  logic [7:0] rd_data_a, rd_data_b;
  logic       mem_we, mem_ra, mem_rb;
  logic [9:0] mem_addr;
  logic [7:0] mem_din, mem_out_a, mem_out_b;

  int total = 0;
  int bad   = 0;
  int onehot_viol = 0;

  always #5 clk = ~clk;

  memory_access_arbiter dut (
    .Clock(clk), .Reset(rst),
    .iWrReq(wr_req), .iWrAddr(wr_addr), .iWrData(wr_data), .oWrAck(wr_ack),
    .iRdReqA(rd_req_a), .iRdReqB(rd_req_b), .iRdAddrA(rd_addr_a), .iRdAddrB(rd_addr_b),
    .oRdAckA(rd_ack_a), .oRdAckB(rd_ack_b), .oRdValidA(rd_valid_a), .oRdValidB(rd_valid_b),
    .oRdDataA(rd_data_a), .oRdDataB(rd_data_b), .oAddrErr(addr_err),
    .oMemWriteEnable(mem_we), .oMemReadtoa(mem_ra), .oMemReadtob(mem_rb),
    .oMemAddress(mem_addr), .oMemDataIn(mem_din),
    .iMemDataOuta(mem_out_a), .iMemDataOutb(mem_out_b)
  );

  // Behavioural MEMORY: words 0..10, registered read outputs.
  logic [7:0] mem [0:10];
  initial begin
    for (int i = 0; i <= 10; i++) mem[i] = 8'hA0 + 8'(i);
    mem_out_a = '0;
    mem_out_b = '0;
  end
  always @(posedge clk) begin
    if (mem_we && mem_addr <= 10) mem[mem_addr] <= mem_din;
    if (mem_ra) mem_out_a <= (mem_addr <= 10) ? mem[mem_addr] : 8'h00;
    if (mem_rb) mem_out_b <= (mem_addr <= 10) ? mem[mem_addr] : 8'h00;
  end

  // Continuous watch for more than one command bit in a cycle.
  always @(negedge clk) begin
    if ((32'(mem_we) + 32'(mem_ra) + 32'(mem_rb)) > 1) onehot_viol++;
  end

  logic [42:0] all_out;
  assign all_out = {wr_ack, rd_ack_a, rd_ack_b, rd_valid_a, rd_valid_b, rd_data_a, rd_data_b,
                    addr_err, mem_we, mem_ra, mem_rb, mem_addr, mem_din};

  // Single write: returns ack cycle (-1 on timeout), error flag and WE at ack.
  task automatic run_write(input logic [9:0] a, input logic [7:0] d,
                           output int ack_cyc, output logic err, output logic we_seen);
    ack_cyc = -1; err = 1'b0; we_seen = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (wr_ack) begin
        ack_cyc = c; err = addr_err; we_seen = mem_we;
        break;
      end
    end
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Single read on port A (port_b=0) or B (port_b=1).
  task automatic run_read(input logic port_b, input logic [9:0] a,
                          output int ack_cyc, output int valid_cyc, output logic err,
                          output logic cmd_seen, output logic [7:0] data);
    ack_cyc = -1; valid_cyc = -1; err = 1'b0; cmd_seen = 1'b0; data = 8'hxx;
    @(negedge clk);
    if (port_b) begin rd_req_b = 1'b1; rd_addr_b = a; end
    else        begin rd_req_a = 1'b1; rd_addr_a = a; end
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (ack_cyc < 0 && (port_b ? rd_ack_b : rd_ack_a)) begin
        ack_cyc = c; err = addr_err; cmd_seen = port_b ? mem_rb : mem_ra;
        rd_req_a = 1'b0; rd_req_b = 1'b0;
      end
      if (port_b ? rd_valid_b : rd_valid_a) begin
        valid_cyc = c; data = port_b ? rd_data_b : rd_data_a;
        break;
      end
    end
    rd_req_a = 1'b0; rd_req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wr_req = 0; rd_req_a = 0; rd_req_b = 0;
    wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== 43'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (all_out !== 43'd0) begin
      bad++; $display("FAIL post_reset_outputs: got %h want 0", all_out);
    end
  endtask

  task automatic test_write_read;
    int ack_c, val_c; logic err, cmd; logic [7:0] d;
    run_write(10'd3, 8'h5A, ack_c, err, cmd);
    total++;
    if (ack_c !== 2) begin bad++; $display("FAIL wr_ack_latency: got %0d want 2", ack_c); end
    total++;
    if ({err, cmd} !== 2'b01) begin bad++; $display("FAIL wr_cmd: err/we got %b want 01", {err, cmd}); end
    run_read(1'b0, 10'd3, ack_c, val_c, err, cmd, d);
    total++;
    if (ack_c !== 2) begin bad++; $display("FAIL rdA_ack_latency: got %0d want 2", ack_c); end
    total++;
    if (val_c !== 4) begin bad++; $display("FAIL rdA_valid_latency: got %0d want 4", val_c); end
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL rdA_data: got %h want 5a", d); end
  endtask

  task automatic test_reset_mid_capture;
    int valids = 0;
    @(negedge clk);
    rd_req_a = 1'b1; rd_addr_a = 10'd3;   // cycle 1: IDLE
    @(negedge clk);                        // cycle 2: ISSUE (ack)
    rd_req_a = 1'b0;
    @(negedge clk);                        // cycle 3: CAPTURE
    rst = 1'b1;
    #1;
    total++;
    if (all_out !== 43'd0) begin
      bad++; $display("FAIL reset_mid_capture: got %h want 0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rd_valid_a) valids++;
    end
    total++;
    if (valids !== 0) begin bad++; $display("FAIL valid_after_reset: got %0d want 0", valids); end
  endtask

  // Pointer is at its reset value here, so the writer is served first.
  task automatic test_all_three;
    int wa = -1, aa = -1, ba = -1, av = -1, bv = -1;
    logic [7:0] ad = 8'hxx, bd = 8'hxx;
    int base = onehot_viol;
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 10'd1; wr_data = 8'h11;
    rd_req_a = 1'b1; rd_addr_a = 10'd1;
    rd_req_b = 1'b1; rd_addr_b = 10'd2;
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if (wr_ack)   begin wa = c; wr_req = 1'b0; end
      if (rd_ack_a) begin aa = c; rd_req_a = 1'b0; end
      if (rd_ack_b) begin ba = c; rd_req_b = 1'b0; end
      if (rd_valid_a) begin av = c; ad = rd_data_a; end
      if (rd_valid_b) begin bv = c; bd = rd_data_b; break; end
    end
    wr_req = 0; rd_req_a = 0; rd_req_b = 0;
    @(negedge clk);
    total++;
    if ({wa, aa, ba} !== {32'd2, 32'd4, 32'd7}) begin
      bad++; $display("FAIL three_ack_order: got W%0d A%0d B%0d want W2 A4 B7", wa, aa, ba);
    end
    total++;
    if (av !== 6 || ad !== 8'h11) begin
      bad++; $display("FAIL three_rdA: got cyc%0d %h want cyc6 11", av, ad);
    end
    total++;
    if (bv !== 9 || bd !== 8'hA2) begin
      bad++; $display("FAIL three_rdB: got cyc%0d %h want cyc9 a2", bv, bd);
    end
    total++;
    if (onehot_viol !== base) begin
      bad++; $display("FAIL three_onehot: got %0d violations want 0", onehot_viol - base);
    end
  endtask

  task automatic test_boundary;
    int ack_c, val_c; logic err, cmd; logic [7:0] d;
    run_write(10'd10, 8'hC3, ack_c, err, cmd);
    total++;
    if (ack_c !== 2 || {err, cmd} !== 2'b01) begin
      bad++; $display("FAIL wr_at_max: got cyc%0d err/we %b want cyc2 01", ack_c, {err, cmd});
    end
    run_read(1'b0, 10'd10, ack_c, val_c, err, cmd, d);
    total++;
    if (val_c !== 4 || d !== 8'hC3 || err !== 1'b0) begin
      bad++; $display("FAIL rd_at_max: got cyc%0d %h err%b want cyc4 c3 err0", val_c, d, err);
    end
    run_read(1'b0, 10'd11, ack_c, val_c, err, cmd, d);
    total++;
    if (ack_c !== 2 || {err, cmd} !== 2'b10) begin
      bad++; $display("FAIL rd_oob_ack: got cyc%0d err/cmd %b want cyc2 10", ack_c, {err, cmd});
    end
    total++;
    if (val_c !== 4 || d !== 8'h00) begin
      bad++; $display("FAIL rd_oob_data: got cyc%0d %h want cyc4 00", val_c, d);
    end
    run_write(10'd11, 8'hEE, ack_c, err, cmd);
    total++;
    if (ack_c !== 2 || {err, cmd} !== 2'b10) begin
      bad++; $display("FAIL wr_oob: got cyc%0d err/we %b want cyc2 10", ack_c, {err, cmd});
    end
    run_read(1'b1, 10'd10, ack_c, val_c, err, cmd, d);
    total++;
    if (val_c !== 4 || d !== 8'hC3) begin
      bad++; $display("FAIL rdB_after_oob_wr: got cyc%0d %h want cyc4 c3", val_c, d);
    end
  endtask

  // Both readers held high: grants must alternate, spaced 3 cycles apart.
  task automatic test_back_to_back;
    int n = 0, na = 0, nb = 0, alt_err = 0, gap_err = 0, last_c = -1, c = 0;
    logic last_b = 1'b0;
    int base = onehot_viol;
    @(negedge clk);
    rd_req_a = 1'b1; rd_addr_a = 10'd1;
    rd_req_b = 1'b1; rd_addr_b = 10'd2;
    while (n < 20 && c < 200) begin
      @(negedge clk);
      c++;
      if (rd_ack_a || rd_ack_b) begin
        if (n > 0 && rd_ack_b == last_b) alt_err++;
        if (n > 0 && (c - last_c) != 3) gap_err++;
        if (rd_ack_b) nb++; else na++;
        last_b = rd_ack_b; last_c = c; n++;
      end
    end
    rd_req_a = 1'b0; rd_req_b = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (n !== 20 || na !== 10 || nb !== 10) begin
      bad++; $display("FAIL rr_counts: got n=%0d A=%0d B=%0d want 20/10/10", n, na, nb);
    end
    total++;
    if (alt_err !== 0) begin bad++; $display("FAIL rr_alternation: got %0d repeats want 0", alt_err); end
    total++;
    if (gap_err !== 0) begin bad++; $display("FAIL rr_spacing: got %0d bad gaps want 0", gap_err); end
    total++;
    if (onehot_viol !== base) begin
      bad++; $display("FAIL rr_onehot: got %0d violations want 0", onehot_viol - base);
    end
  endtask

  task automatic test_idle;
    int busy = 0;
    repeat (10) begin
      @(negedge clk);
      if ({wr_ack, rd_ack_a, rd_ack_b, rd_valid_a, rd_valid_b, addr_err,
           mem_we, mem_ra, mem_rb, mem_addr, mem_din} !== 29'd0) busy++;
    end
    total++;
    if (busy !== 0) begin bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid_capture();
    test_all_three();
    test_boundary();
    test_back_to_back();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
